// File: rtl/lzd_norm_pipe.sv
// lzd_norm_pipe: two-stage LZA-driven normalizer (priority encode, then shift and exponent adjust).
// Define LZD_NORM_CORRECT_EN to enable the one-bit LZA correction in stage 2.
module lzd_norm_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] ind_in,
  input  logic [MANT_W-1:0] sum_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [4:0]        lz_out,
  output logic              zero_out,
  output logic              uf_out
);
  logic              s1_valid_q, s2_valid_q, s1_load, s2_load;
  logic [4:0]        cnt_q, cnt_d, lz_s, lz_d;
  logic [MANT_W-1:0] sum_q, sh0, mant_s, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              corr, zero_d, under, uf_d;
  assign s2_load   = !s2_valid_q || out_ready;
  assign s1_load   = !s1_valid_q || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  // ascending scan: the highest set bit wins; an all-zero indicator falls back to MANT_W-1
  always_comb begin
    cnt_d = 5'(MANT_W-1);
    for (int i = 0; i < MANT_W; i++) if (ind_in[i]) cnt_d = 5'(MANT_W-1-i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      exp_q      <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        cnt_q <= cnt_d;
        sum_q <= sum_in;
        exp_q <= exp_in;
      end
    end
  end
  always_comb begin
    sh0 = sum_q << cnt_q;
`ifdef LZD_NORM_CORRECT_EN
    corr = !sh0[MANT_W-1] && (|sum_q);
`else
    corr = 1'b0;
`endif
    mant_s = corr ? sh0 << 1 : sh0;
    lz_s   = cnt_q + 5'(corr);
    zero_d = ~|sum_q;
    under  = exp_q <= EXP_W'(lz_s);
    mant_d = zero_d ? '0 : mant_s;
    lz_d   = zero_d ? '0 : lz_s;
    uf_d   = !zero_d && under;
    exp_d  = (zero_d || under) ? '0 : exp_q - EXP_W'(lz_s);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      mant_out   <= '0;
      exp_out    <= '0;
      lz_out     <= '0;
      zero_out   <= 1'b0;
      uf_out     <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        mant_out <= mant_d;
        exp_out  <= exp_d;
        lz_out   <= lz_d;
        zero_out <= zero_d;
        uf_out   <= uf_d;
      end
    end
  end
endmodule

// File: tb/tb_lzd_norm_pipe.sv
// tb_lzd_norm_pipe: directed and randomized checks of lzd_norm_pipe against an arithmetic reference model.
module tb_lzd_norm_pipe;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [26:0] ind_in = '0, sum_in = '0, mant_out;
  logic [7:0]  exp_in = '0, exp_out;
  logic [4:0]  lz_out;
  logic        zero_out, uf_out;
  int          n_checks = 0, n_fail = 0;
  logic [41:0] q[$];
  logic        in_fire, rand_ready = 1'b0;
  logic [41:0] snap;

  lzd_norm_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ind_in(ind_in), .sum_in(sum_in), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready), .mant_out(mant_out),
    .exp_out(exp_out), .lz_out(lz_out), .zero_out(zero_out), .uf_out(uf_out)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] model(logic [26:0] ind, logic [26:0] sum, logic [7:0] e);
    longint m;
    int c, h, ee;
    logic uf;
    if (sum == 0) return {27'd0, 8'd0, 5'd0, 1'b1, 1'b0};
    h = 0;
    while (h < 26 && (ind >> (h + 1)) != 0) h++;
    c = 26 - h;
    m = (longint'(sum) * (longint'(1) << c)) % (longint'(1) << 27);
`ifdef LZD_NORM_CORRECT_EN
    if (m < (longint'(1) << 26)) begin
      c++;
      m = (m * 2) % (longint'(1) << 27);
    end
`endif
    uf = !(int'(e) > c);
    ee = uf ? 0 : int'(e) - c;
    return {27'(m), 8'(ee), 5'(c), 1'b0, uf};
  endfunction

  function automatic logic [41:0] outs();
    return {mant_out, exp_out, lz_out, zero_out, uf_out};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    in_fire = in_valid && in_ready;
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else begin
        chk("beat", 64'(outs()), 64'(q[0]));
        if (out_ready) void'(q.pop_front());
      end
    end
    if (in_fire) q.push_back(model(ind_in, sum_in, exp_in));
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom % 5) != 0;
  endtask

  task automatic send(logic [26:0] ind, logic [26:0] sum, logic [7:0] e);
    int n;
    in_valid = 1'b1; ind_in = ind; sum_in = sum; exp_in = e;
    n = 0;
    do begin cyc(); n++; end while (!in_fire && n < 60);
    if (!in_fire) chk("send_timeout", 64'(n), 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin cyc(); n++; end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic directed(string tag, logic [26:0] ind, logic [26:0] sum, logic [7:0] e,
                          logic [26:0] em, logic [7:0] ee, logic [4:0] el, logic ez, logic eu);
    send(ind, sum, e);
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    cyc();
    chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
    chk(tag, 64'(outs()), 64'({em, ee, el, ez, eu}));
    drain();
  endtask

  initial begin
    logic [26:0] ind, sum;
    int p;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outs", 64'(outs()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    cyc();
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_outs", 64'(outs()), 64'd0);

    directed("norm", 27'h0400000, 27'h0400000, 8'd100, 27'h4000000, 8'd96, 5'd4, 1'b0, 1'b0);
`ifdef LZD_NORM_CORRECT_EN
    directed("corr", 27'h0400000, 27'h0200000, 8'd100, 27'h4000000, 8'd95, 5'd5, 1'b0, 1'b0);
`else
    directed("nocorr", 27'h0400000, 27'h0200000, 8'd100, 27'h2000000, 8'd96, 5'd4, 1'b0, 1'b0);
`endif
    directed("zero", 27'h0400000, 27'h0, 8'd50, 27'h0, 8'd0, 5'd0, 1'b1, 1'b0);
    directed("uflow", 27'h0400000, 27'h0400000, 8'd3, 27'h4000000, 8'd0, 5'd4, 1'b0, 1'b1);
    directed("eq_uflow", 27'h0400000, 27'h0400000, 8'd4, 27'h4000000, 8'd0, 5'd4, 1'b0, 1'b1);
    directed("ind_zero", 27'h0, 27'h1, 8'd200, 27'h4000000, 8'd174, 5'd26, 1'b0, 1'b0);
    directed("top_bit", 27'h4000001, 27'h5A5A5A5, 8'd1, 27'h5A5A5A5, 8'd1, 5'd0, 1'b0, 1'b0);

    out_ready = 1'b0;
    send(27'h0000100, 27'h0000155, 8'd20);
    send(27'h0001000, 27'h0001ABC, 8'd30);
    in_valid = 1'b1; ind_in = 27'h0010000; sum_in = 27'h0012345; exp_in = 8'd40;
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    snap = outs();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_in_ready_k", 64'(in_ready), 64'd0);
      chk("stall_stable", 64'(outs()), 64'(snap));
    end
    out_ready = 1'b1;
    send(27'h0010000, 27'h0012345, 8'd40);
    send(27'h0100000, 27'h00FFFFF, 8'd60);
    drain();

    for (int k = 0; k < 6; k++) send(27'(k + 1) << (3 * k), 27'h7654321 >> k, 8'(10 * k + 5));
    drain();

    out_ready = 1'b0;
    send(27'h0000800, 27'h0000F00, 8'd77);
    send(27'h0020000, 27'h0030000, 8'd88);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_outs", 64'(outs()), 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("midrst_no_ghost", 64'(out_valid), 64'd0);
    end

    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      p = $urandom % 27;
      ind = (27'd1 << p) | (27'($urandom) & ((27'd1 << p) - 27'd1));
      if ($urandom % 20 == 0) ind = '0;
      sum = 27'($urandom) & ((27'd1 << (p + 1)) - 27'd1);
      if ($urandom % 10 == 0) sum = '0;
      send(ind, sum, ($urandom % 3 == 0) ? 8'($urandom % 8) : 8'($urandom));
      if ($urandom % 4 == 0) cyc();
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
